// File: rtl/factorial_seq_engine_if.sv
// Operand/result handshake bundle for the sequential factorial engine.
// The source/consumer side is the master; the engine is the slave.
interface factorial_seq_engine_if #(
  parameter int N_WIDTH   = 4,
  parameter int OUT_WIDTH = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [N_WIDTH-1:0]   number;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out;
  logic                 overflow;

  modport master (
    output in_valid, number, out_ready,
    input  in_ready, out_valid, out, overflow
  );

  modport slave (
    input  in_valid, number, out_ready,
    output in_ready, out_valid, out, overflow
  );
endinterface

// File: rtl/factorial_seq_engine.sv
// Multi-cycle factorial unit: accepts n over a valid/ready port, computes n! by
// repeated multiply-decrement, returns the truncated result plus an overflow flag.
module factorial_seq_engine #(
  parameter int N_WIDTH   = 4,
  parameter int OUT_WIDTH = 32
) (
  input logic                  clock,
  input logic                  reset_n,
  factorial_seq_engine_if.slave io
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                 state;
  logic [OUT_WIDTH-1:0]   acc;
  logic [N_WIDTH-1:0]     cnt;
  logic                   ovf;
  logic [2*OUT_WIDTH-1:0] prod;

  // Full-width product so bits lost to truncation can be seen for the overflow flag.
  assign prod = {{OUT_WIDTH{1'b0}}, acc} * {{(2*OUT_WIDTH-N_WIDTH){1'b0}}, cnt};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      io.in_ready  <= 1'b1;
      io.out_valid <= 1'b0;
      io.out       <= '0;
      io.overflow  <= 1'b0;
      acc          <= '0;
      cnt          <= '0;
      ovf          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (io.in_valid) begin
            cnt         <= io.number;
            acc         <= {{(OUT_WIDTH-1){1'b0}}, 1'b1};
            ovf         <= 1'b0;
            io.in_ready <= 1'b0;
            state       <= CALC;
          end
        end
        CALC: begin
          if (cnt > N_WIDTH'(1)) begin
            acc <= prod[OUT_WIDTH-1:0];
            cnt <= cnt - N_WIDTH'(1);
            if (|prod[2*OUT_WIDTH-1:OUT_WIDTH]) ovf <= 1'b1;
          end else begin
            io.out       <= acc;
            io.overflow  <= ovf;
            io.out_valid <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          // out/overflow keep their values after the handshake
          if (io.out_ready) begin
            io.out_valid <= 1'b0;
            io.in_ready  <= 1'b1;
            state        <= IDLE;
          end
        end
        default: begin
          io.out_valid <= 1'b0;
          io.in_ready  <= 1'b1;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_factorial_seq_engine.sv
// Directed bench for factorial_seq_engine: hand-computed results, latency,
// backpressure, back-to-back operands and reset abort.
module tb_factorial_seq_engine;

  logic clock;
  logic reset_n;
  int   nvec = 0;
  int   nerr = 0;

  factorial_seq_engine_if #(.N_WIDTH(4), .OUT_WIDTH(32)) io ();

  factorial_seq_engine #(.N_WIDTH(4), .OUT_WIDTH(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .io      (io)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; leaves in_valid low at the negedge after acceptance.
  task automatic accept(input string tag, input logic [3:0] n);
    int w = 0;
    io.in_valid = 1'b1;
    io.number   = n;
    while (!io.in_ready && w < 64) begin @(posedge clock); @(negedge clock); w++; end
    chk({tag, "_rdy"}, io.in_ready, 1'b1);
    @(posedge clock);
    @(negedge clock);
    io.in_valid = 1'b0;
    chk({tag, "_busy"}, io.in_ready, 1'b0);
  endtask

  task automatic wait_result(input string tag, input int exp_lat,
                             input logic [31:0] exp_out, input logic exp_ovf);
    int lat = 0;
    while (!io.out_valid && lat < 64) begin
      @(posedge clock); lat++; @(negedge clock);
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_out"}, io.out, exp_out);
    chk({tag, "_ovf"}, io.overflow, exp_ovf);
  endtask

  task automatic release_result(input string tag);
    @(posedge clock);
    @(negedge clock);
    chk({tag, "_vld_clr"}, io.out_valid, 1'b0);
    chk({tag, "_idle"}, io.in_ready, 1'b1);
  endtask

  logic [31:0] fact_tab [0:6] = '{32'd1, 32'd1, 32'd2, 32'd6, 32'd24, 32'd120, 32'd720};

  initial begin
    io.in_valid  = 1'b0;
    io.number    = '0;
    io.out_ready = 1'b1;
    reset_n      = 1'b0;

    // reset
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_out", io.out, 0);
    chk("rst_ovf", io.overflow, 0);
    chk("rst_vld", io.out_valid, 0);
    chk("rst_rdy", io.in_ready, 1);
    reset_n = 1'b1;
    @(negedge clock);

    // sweep 0..6
    for (int n = 0; n <= 6; n++) begin
      string t;
      t = $sformatf("sweep%0d", n);
      accept(t, 4'(n));
      wait_result(t, (n < 1) ? 1 : n, fact_tab[n], 1'b0);
      release_result(t);
    end

    // overflow boundary
    accept("n12", 4'd12);
    wait_result("n12", 12, 32'd479001600, 1'b0);
    release_result("n12");
    accept("n13", 4'd13);
    wait_result("n13", 13, 32'd1932053504, 1'b1);
    release_result("n13");
    accept("n15", 4'd15);
    wait_result("n15", 15, 32'd2004310016, 1'b1);
    release_result("n15");

    // backpressure: a competing operand must not be taken while the result is held
    io.out_ready = 1'b0;
    accept("bp", 4'd4);
    wait_result("bp", 4, 32'd24, 1'b0);
    io.in_valid = 1'b1;
    io.number   = 4'd7;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      @(negedge clock);
      chk($sformatf("bp_vld%0d", i), io.out_valid, 1'b1);
      chk($sformatf("bp_out%0d", i), io.out, 32'd24);
      chk($sformatf("bp_rdy%0d", i), io.in_ready, 1'b0);
    end
    io.in_valid  = 1'b0;
    io.out_ready = 1'b1;
    release_result("bp");

    // back-to-back with in_valid held high
    io.in_valid = 1'b1;
    io.number   = 4'd3;
    @(posedge clock);
    @(negedge clock);
    chk("b2b_a_busy", io.in_ready, 1'b0);
    io.number = 4'd5;
    wait_result("b2b_a", 3, 32'd6, 1'b0);
    @(posedge clock);
    @(negedge clock);
    chk("b2b_a_clr", io.out_valid, 1'b0);
    chk("b2b_b_rdy", io.in_ready, 1'b1);
    @(posedge clock);
    @(negedge clock);
    io.in_valid = 1'b0;
    chk("b2b_b_busy", io.in_ready, 1'b0);
    wait_result("b2b_b", 5, 32'd120, 1'b0);
    release_result("b2b_b");
    for (int i = 0; i < 8; i++) begin
      @(posedge clock);
      @(negedge clock);
      chk($sformatf("b2b_nodup%0d", i), io.out_valid, 1'b0);
    end

    // reset during CALC aborts the operation
    accept("abort", 4'd10);
    repeat (3) begin @(posedge clock); @(negedge clock); end
    reset_n = 1'b0;
    #1;
    chk("abort_vld", io.out_valid, 1'b0);
    chk("abort_rdy", io.in_ready, 1'b1);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clock);
      @(negedge clock);
      chk($sformatf("abort_quiet%0d", i), io.out_valid, 1'b0);
    end
    accept("post", 4'd2);
    wait_result("post", 2, 32'd2, 1'b0);
    release_result("post");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
